// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD burst arbiter.
//   arb_state_e : arbitration FSM encoding (IDLE / XFER / GAP)
//   owner_e     : which requester currently owns, or last owned, the byte path
//   LCD_BYTE_W  : width of one LCD byte
package lcd_pkg;

  localparam int LCD_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_BRD = 1'b0,
    OWN_STS = 1'b1
  } owner_e;

endpackage

// File: rtl/lcd_out_stage.sv
// One-entry registered output buffer between the arbiter and LCD_control.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_data    : byte offered by the arbiter (already gated by in_ready)
//   in_ready              : buffer can take a byte this cycle
//   out_data / out_valid  : registered byte towards LCD_control
//   out_ready             : LCD_control takes the byte this cycle (en_tran)
//   empty_next            : buffer will be empty after this clock edge
module lcd_out_stage
  import lcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [LCD_BYTE_W-1:0] in_data,
  output logic                  in_ready,
  output logic [LCD_BYTE_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty_next
);

  logic                  valid_q, valid_d;
  logic [LCD_BYTE_W-1:0] data_q, data_d;

  // A new byte may enter while the current one leaves, giving one byte per cycle.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign empty_next = !valid_d;
  assign out_data   = data_q;
  assign out_valid  = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lcd_burst_arbiter.sv
// Burst arbiter sharing the LCD byte path between the board and status renderers.
// Grants whole bursts of BURST_LEN bytes round-robin, forwards bytes through a
// one-entry output stage and idles GAP_CYCLES after every burst.
// Ports:
//   brd_* / sts_*        : requester handshakes (req, data, valid, ready, grant, done)
//   lcd_data(_valid)     : byte stream to LCD_control
//   lcd_en_tran          : LCD_control takes the current byte
//   busy                 : FSM not in IDLE
//   aborted              : one-cycle pulse when a burst ended early
module lcd_burst_arbiter
  import lcd_pkg::*;
#(
  parameter int BURST_LEN  = 64,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  brd_req,
  input  logic [LCD_BYTE_W-1:0] brd_data,
  input  logic                  brd_valid,
  output logic                  brd_ready,
  output logic                  brd_grant,
  output logic                  brd_done,
  input  logic                  sts_req,
  input  logic [LCD_BYTE_W-1:0] sts_data,
  input  logic                  sts_valid,
  output logic                  sts_ready,
  output logic                  sts_grant,
  output logic                  sts_done,
  output logic [LCD_BYTE_W-1:0] lcd_data,
  output logic                  lcd_data_valid,
  input  logic                  lcd_en_tran,
  output logic                  busy,
  output logic                  aborted
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;
  logic             brd_done_q, brd_done_d;
  logic             sts_done_q, sts_done_d;
  logic             aborted_q, aborted_d;

  logic                  owner_req, sel_valid, take, stage_ready, stage_empty_next;
  logic                  finish, abort_end;
  logic [LCD_BYTE_W-1:0] sel_data;

  assign owner_req = (owner_q == OWN_STS) ? sts_req   : brd_req;
  assign sel_valid = (owner_q == OWN_STS) ? sts_valid : brd_valid;
  assign sel_data  = (owner_q == OWN_STS) ? sts_data  : brd_data;

  // Once the owner's req has dropped (now or earlier) nothing more is taken.
  assign take = (state_q == XFER) && (cnt_q != '0) && owner_req && !abort_q && stage_ready;

  assign brd_ready = take && (owner_q == OWN_BRD);
  assign sts_ready = take && (owner_q == OWN_STS);
  assign brd_grant = (state_q == XFER) && (owner_q == OWN_BRD);
  assign sts_grant = (state_q == XFER) && (owner_q == OWN_STS);
  assign busy      = (state_q != IDLE);
  assign brd_done  = brd_done_q;
  assign sts_done  = sts_done_q;
  assign aborted   = aborted_q;

  lcd_out_stage u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (take && sel_valid),
    .in_data    (sel_data),
    .in_ready   (stage_ready),
    .out_data   (lcd_data),
    .out_valid  (lcd_data_valid),
    .out_ready  (lcd_en_tran),
    .empty_next (stage_empty_next)
  );

  // Leaving XFER looks at the buffer state after this edge, so the cycle that
  // drains the last byte is also the last XFER cycle (BURST_LEN + 1 in total).
  assign finish    = (state_q == XFER) && stage_empty_next && (cnt_q == '0);
  assign abort_end = (state_q == XFER) && stage_empty_next && !finish && (abort_q || !owner_req);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    abort_d      = abort_q;
    brd_done_d   = 1'b0;
    sts_done_d   = 1'b0;
    aborted_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (brd_req || sts_req) begin
          if (brd_req && sts_req)
            owner_d = (last_owner_q == OWN_STS) ? OWN_BRD : OWN_STS;
          else
            owner_d = brd_req ? OWN_BRD : OWN_STS;
          cnt_d   = CNT_LOAD;
          abort_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (take && sel_valid)
          cnt_d = cnt_q - CNT_W'(1);
        if (!owner_req)
          abort_d = 1'b1;
        if (finish || abort_end) begin
          state_d      = GAP;
          gap_d        = GAP_LOAD;
          last_owner_d = owner_q;
          brd_done_d   = finish && (owner_q == OWN_BRD);
          sts_done_d   = finish && (owner_q == OWN_STS);
          aborted_d    = abort_end;
        end
      end
      GAP: begin
        if (gap_q == '0)
          state_d = IDLE;
        else
          gap_d = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_BRD;
      last_owner_q <= OWN_STS;
      cnt_q        <= '0;
      gap_q        <= '0;
      abort_q      <= 1'b0;
      brd_done_q   <= 1'b0;
      sts_done_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      abort_q      <= abort_d;
      brd_done_q   <= brd_done_d;
      sts_done_q   <= sts_done_d;
      aborted_q    <= aborted_d;
    end
  end

endmodule

// File: tb/tb_lcd_burst_arbiter.sv
// Directed testbench for lcd_burst_arbiter (BURST_LEN=64, GAP_CYCLES=4).
module tb_lcd_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brd_req = 1'b0, brd_valid = 1'b0, sts_req = 1'b0, sts_valid = 1'b0;
  logic [7:0] brd_data = 8'h00, sts_data = 8'h00;
  logic       lcd_en_tran = 1'b1;
  logic       brd_ready, brd_grant, brd_done, sts_ready, sts_grant, sts_done;
  logic [7:0] lcd_data;
  logic       lcd_data_valid, busy, aborted;

  always #5 clk = ~clk;

  lcd_burst_arbiter #(.BURST_LEN(64), .GAP_CYCLES(4), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .brd_req(brd_req), .brd_data(brd_data), .brd_valid(brd_valid), .brd_ready(brd_ready),
    .brd_grant(brd_grant), .brd_done(brd_done),
    .sts_req(sts_req), .sts_data(sts_data), .sts_valid(sts_valid), .sts_ready(sts_ready),
    .sts_grant(sts_grant), .sts_done(sts_done),
    .lcd_data(lcd_data), .lcd_data_valid(lcd_data_valid), .lcd_en_tran(lcd_en_tran),
    .busy(busy), .aborted(aborted)
  );

  int tests_run = 0, tests_failed = 0;

  logic [7:0] lcd_log[$];
  bit         done_who[$];
  int         brd_idx, sts_idx, brd_acc_n, sts_acc_n;
  logic       brd_acc, sts_acc;
  int         brd_done_n, sts_done_n, abort_n, brd_grant_n;
  int         ready_viol, hold_viol, cyc;
  bit         sts_aa, en_toggle, drop_sts_at10;
  logic       prev_valid, prev_en;
  logic [7:0] prev_data;
  logic [3:0] en_pat = 4'b1001;

  task automatic clear_stats();
    lcd_log.delete();
    done_who.delete();
    brd_idx = 0; sts_idx = 0; brd_acc_n = 0; sts_acc_n = 0;
    brd_acc = 1'b0; sts_acc = 1'b0;
    brd_done_n = 0; sts_done_n = 0; abort_n = 0; brd_grant_n = 0;
    ready_viol = 0; hold_viol = 0; cyc = 0;
    sts_aa = 1'b0; en_toggle = 1'b0; drop_sts_at10 = 1'b0;
    prev_valid = 1'b0; prev_en = 1'b1; prev_data = 8'h00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    brd_req = 1'b0; sts_req = 1'b0; brd_valid = 1'b0; sts_valid = 1'b0;
    brd_data = 8'h00; sts_data = 8'hC0; lcd_en_tran = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive inputs just after the rising edge, observe just before the next one.
  task automatic cycle();
    @(posedge clk); #1;
    if (brd_acc) brd_idx++;
    if (sts_acc) sts_idx++;
    if (drop_sts_at10 && sts_acc_n == 10) sts_req = 1'b0;
    brd_data    = 8'(brd_idx);
    sts_data    = sts_aa ? 8'hAA : (8'hC0 | 8'(sts_idx & 63));
    lcd_en_tran = en_toggle ? en_pat[cyc % 4] : 1'b1;
    cyc++;
    @(negedge clk);
    brd_acc = brd_valid && brd_ready;
    sts_acc = sts_valid && sts_ready;
    if (brd_acc) brd_acc_n++;
    if (sts_acc) sts_acc_n++;
    if ((brd_ready && !brd_grant) || (sts_ready && !sts_grant)) ready_viol++;
    if (prev_valid && !prev_en && (!lcd_data_valid || lcd_data !== prev_data)) hold_viol++;
    prev_valid = lcd_data_valid; prev_en = lcd_en_tran; prev_data = lcd_data;
    if (lcd_data_valid && lcd_en_tran) lcd_log.push_back(lcd_data);
    if (brd_grant) brd_grant_n++;
    if (brd_done) begin
      brd_done_n++; done_who.push_back(1'b0);
      $display("[TB] t=%0t board burst done, %0d bytes logged", $time, lcd_log.size());
    end
    if (sts_done) begin
      sts_done_n++; done_who.push_back(1'b1);
      $display("[TB] t=%0t status burst done, %0d bytes logged", $time, lcd_log.size());
    end
    if (aborted) begin
      abort_n++;
      $display("[TB] t=%0t burst aborted, %0d bytes logged", $time, lcd_log.size());
    end
  endtask

  task automatic test_reset();
    clear_stats();
    rst_n = 1'b0; brd_req = 1'b1; brd_valid = 1'b1; sts_req = 1'b1; sts_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({brd_grant, sts_grant, brd_done, sts_done, brd_ready, sts_ready,
         lcd_data_valid, busy, aborted} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, want 000000000",
               {brd_grant, sts_grant, brd_done, sts_done, brd_ready, sts_ready,
                lcd_data_valid, busy, aborted});
    end
    tests_run++;
    if (lcd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_lcd_data: got %h, want 00", lcd_data);
    end
    brd_req = 1'b0; sts_req = 1'b0; brd_valid = 1'b0; sts_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cycle(); cycle();
    tests_run++;
    if (busy !== 1'b0 || brd_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b grant=%b, want 0 0", busy, brd_grant);
    end
  endtask

  task automatic test_single_burst();
    int order_err = 0;
    int gap_busy = 1;
    clear_stats();
    apply_reset();
    brd_req = 1'b1; brd_valid = 1'b1;
    cycle();
    tests_run++;
    if (brd_grant !== 1'b1 || sts_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_grant_cycle1: brd=%b sts=%b, want 1 0", brd_grant, sts_grant);
    end
    for (int n = 0; n < 200 && brd_done_n == 0; n++) cycle();
    tests_run++;
    if (brd_done_n == 0) begin
      tests_failed++;
      $display("FAIL single_timeout: brd_done not seen, want 1 pulse");
    end
    brd_req = 1'b0; brd_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle();
      if (busy && !brd_grant && !sts_grant) gap_busy++;
    end
    cycle();
    tests_run++;
    if (gap_busy != 4 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_gap: gap cycles=%0d busy after=%b, want 4 0", gap_busy, busy);
    end
    tests_run++;
    if (brd_done_n != 1) begin
      tests_failed++;
      $display("FAIL single_done_count: got %0d, want 1", brd_done_n);
    end
    tests_run++;
    if (brd_grant_n != 65) begin
      tests_failed++;
      $display("FAIL single_xfer_cycles: got %0d, want 65", brd_grant_n);
    end
    for (int i = 0; i < lcd_log.size(); i++) if (lcd_log[i] !== 8'(i)) order_err++;
    tests_run++;
    if (lcd_log.size() != 64 || order_err != 0) begin
      tests_failed++;
      $display("FAIL single_bytes: count=%0d order errors=%0d, want 64 0", lcd_log.size(), order_err);
    end
  endtask

  task automatic test_alternation();
    logic [3:0] got = 4'b0;
    clear_stats();
    apply_reset();
    brd_req = 1'b1; sts_req = 1'b1; brd_valid = 1'b1; sts_valid = 1'b1;
    cycle();
    tests_run++;
    if (brd_grant !== 1'b1 || sts_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_first_owner: brd=%b sts=%b, want 1 0", brd_grant, sts_grant);
    end
    for (int n = 0; n < 1000 && done_who.size() < 4; n++) cycle();
    for (int i = 0; i < 4 && i < done_who.size(); i++) got[i] = done_who[i];
    tests_run++;
    if (done_who.size() != 4 || got !== 4'b1010) begin
      tests_failed++;
      $display("FAIL alt_order: bursts=%0d order=%b, want 4 1010", done_who.size(), got);
    end
    tests_run++;
    if (lcd_log.size() != 256) begin
      tests_failed++;
      $display("FAIL alt_bytes: got %0d, want 256", lcd_log.size());
    end
    brd_req = 1'b0; sts_req = 1'b0;
  endtask

  task automatic test_backpressure();
    int order_err = 0;
    clear_stats();
    apply_reset();
    en_toggle = 1'b1;
    brd_req = 1'b1; brd_valid = 1'b1;
    for (int n = 0; n < 400 && brd_done_n == 0; n++) cycle();
    brd_req = 1'b0;
    for (int i = 0; i < lcd_log.size(); i++) if (lcd_log[i] !== 8'(i)) order_err++;
    tests_run++;
    if (brd_done_n != 1 || lcd_log.size() != 64 || order_err != 0) begin
      tests_failed++;
      $display("FAIL bp_bytes: done=%0d count=%0d order errors=%0d, want 1 64 0",
               brd_done_n, lcd_log.size(), order_err);
    end
    tests_run++;
    if (hold_viol != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: %0d unstable stalled cycles, want 0", hold_viol);
    end
  endtask

  task automatic test_abort();
    int data_err = 0;
    clear_stats();
    apply_reset();
    drop_sts_at10 = 1'b1;
    sts_req = 1'b1; sts_valid = 1'b1;
    for (int n = 0; n < 200 && abort_n == 0; n++) cycle();
    tests_run++;
    if (abort_n != 1 || busy !== 1'b1 || sts_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_pulse: aborts=%0d busy=%b grant=%b, want 1 1 0", abort_n, busy, sts_grant);
    end
    repeat (6) cycle();
    for (int i = 0; i < lcd_log.size(); i++) if (lcd_log[i] !== (8'hC0 | 8'(i))) data_err++;
    tests_run++;
    if (lcd_log.size() != 10 || sts_acc_n != 10 || data_err != 0) begin
      tests_failed++;
      $display("FAIL abort_bytes: lcd=%0d accepted=%0d data errors=%0d, want 10 10 0",
               lcd_log.size(), sts_acc_n, data_err);
    end
    tests_run++;
    if (sts_done_n != 0 || abort_n != 1) begin
      tests_failed++;
      $display("FAIL abort_no_done: done=%0d aborts=%0d, want 0 1", sts_done_n, abort_n);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    apply_reset();
    brd_req = 1'b1; brd_valid = 1'b1;
    for (int n = 0; n < 200 && brd_done_n == 0; n++) cycle();
    brd_req = 1'b0; brd_valid = 1'b0;
    sts_req = 1'b1; sts_valid = 1'b1;
    for (int n = 0; n < 200 && sts_acc_n < 20; n++) cycle();
    tests_run++;
    if (sts_acc_n != 20 || sts_grant !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup: accepted=%0d grant=%b, want 20 1", sts_acc_n, sts_grant);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({brd_grant, sts_grant, sts_ready, lcd_data_valid, busy, aborted, sts_done} !== 7'b0 ||
        lcd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_clear: flags=%b data=%h, want 0000000 00",
               {brd_grant, sts_grant, sts_ready, lcd_data_valid, busy, aborted, sts_done}, lcd_data);
    end
    brd_req = 1'b1; brd_valid = 1'b1; sts_req = 1'b1; sts_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    cycle();
    tests_run++;
    if (brd_grant !== 1'b1 || sts_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_tie: brd=%b sts=%b, want 1 0", brd_grant, sts_grant);
    end
    brd_req = 1'b0; sts_req = 1'b0;
  endtask

  task automatic test_nonowner();
    int aa_cnt = 0;
    clear_stats();
    apply_reset();
    brd_req = 1'b1; brd_valid = 1'b1;
    cycle();
    sts_aa = 1'b1; sts_req = 1'b1; sts_valid = 1'b1;
    for (int n = 0; n < 200 && brd_done_n == 0; n++) cycle();
    brd_req = 1'b0; brd_valid = 1'b0;
    for (int i = 0; i < lcd_log.size(); i++) if (lcd_log[i] === 8'hAA) aa_cnt++;
    tests_run++;
    if (ready_viol != 0 || aa_cnt != 0 || lcd_log.size() != 64) begin
      tests_failed++;
      $display("FAIL nonowner_blocked: ready leaks=%0d AA bytes=%0d count=%0d, want 0 0 64",
               ready_viol, aa_cnt, lcd_log.size());
    end
    for (int n = 0; n < 200 && sts_done_n == 0; n++) cycle();
    tests_run++;
    if (lcd_log.size() != 128 || lcd_log[64] !== 8'hAA || lcd_log[127] !== 8'hAA) begin
      tests_failed++;
      $display("FAIL nonowner_own_grant: count=%0d, want 128 with AA bytes from index 64",
               lcd_log.size());
    end
    sts_req = 1'b0; sts_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_alternation();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_nonowner();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
